// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE -> RUN -> HALTED, driving the instruction ROM address.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PROG_END = 1023
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Branch_en,
  input  logic [PC_W-1:0] Target,
  input  logic            Halt,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic [15:0]     InstrCount,
  output logic [15:0]     BranchCount
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] END_PC = PC_W'(PROG_END);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  // Next-state and PC sequencing; halt beats branch beats end-of-program.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (Branch_en) begin
          pc_d = Target;
        end else if (pc_q == END_PC) begin
          state_d = ST_HALTED;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RST_PC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic        start_acc, run_edge, br_taken;

  // Saturating counters; an accepted Start clears them ahead of any increment.
  always_comb begin
    run_edge     = (state_q == ST_RUN);
    br_taken     = run_edge && !Halt && Branch_en;
    start_acc    = !run_edge && Start;
    instr_cnt_d  = instr_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (start_acc) begin
      instr_cnt_d  = 16'd0;
      branch_cnt_d = 16'd0;
    end else begin
      if (run_edge && (instr_cnt_q != 16'hFFFF)) instr_cnt_d = instr_cnt_q + 16'd1;
      if (br_taken && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_cnt_q  <= 16'd0;
      branch_cnt_q <= 16'd0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign InstrCount  = instr_cnt_q;
  assign BranchCount = branch_cnt_q;
`else
  assign InstrCount  = 16'd0;
  assign BranchCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Branch_en;
  logic [9:0]  Target;
  logic        Halt;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] InstrCount;
  logic [15:0] BranchCount;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_W(10), .RESET_PC(0), .PROG_END(1023)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Branch_en(Branch_en), .Target(Target), .Halt(Halt),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstrCount(InstrCount), .BranchCount(BranchCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic [9:0]  addr;
    logic        br;
    logic [9:0]  tgt;
    logic        halt;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] ic;
    logic [15:0] bc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic s, int a, logic b, int t, logic h,
                              int pc, logic r, logic d, int ic, int bc);
    vec_t v;
    v.start = s;  v.addr = 10'(a); v.br = b; v.tgt = 10'(t); v.halt = h;
    v.pc = 10'(pc); v.run = r; v.done = d; v.ic = 16'(ic); v.bc = 16'(bc);
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic check_all(int idx, logic [9:0] pc, logic r, logic d, logic [15:0] ic, logic [15:0] bc);
    check("ProgCtr", idx, 32'(ProgCtr), 32'(pc));
    check("Running", idx, 32'(Running), 32'(r));
    check("Done", idx, 32'(Done), 32'(d));
    check("InstrCount", idx, 32'(InstrCount), PERF ? 32'(ic) : 32'd0);
    check("BranchCount", idx, 32'(BranchCount), PERF ? 32'(bc) : 32'd0);
  endtask

  task automatic drive(logic s, logic [9:0] a, logic b, logic [9:0] t, logic h);
    Start = s; StartAddr = a; Branch_en = b; Target = t; Halt = h;
  endtask

  initial begin
    //            st  addr br tgt  h   pc  run dn ic bc
    vecs[0]  = mk(1,  5,   0, 0,   0,  5,  1, 0, 0, 0);
    vecs[1]  = mk(0,  0,   0, 0,   0,  6,  1, 0, 1, 0);
    vecs[2]  = mk(0,  0,   0, 0,   0,  7,  1, 0, 2, 0);
    vecs[3]  = mk(0,  0,   0, 0,   0,  8,  1, 0, 3, 0);
    vecs[4]  = mk(0,  0,   0, 0,   1,  8,  0, 1, 4, 0);
    vecs[5]  = mk(0,  0,   0, 0,   0,  8,  0, 1, 4, 0);
    vecs[6]  = mk(0,  0,   1, 50,  0,  8,  0, 1, 4, 0);
    vecs[7]  = mk(1,  10,  0, 0,   0,  10, 1, 0, 0, 0);
    vecs[8]  = mk(0,  0,   0, 0,   0,  11, 1, 0, 1, 0);
    vecs[9]  = mk(0,  0,   0, 0,   0,  12, 1, 0, 2, 0);
    vecs[10] = mk(0,  0,   1, 3,   0,  3,  1, 0, 3, 1);
    vecs[11] = mk(0,  0,   0, 0,   0,  4,  1, 0, 4, 1);
    vecs[12] = mk(1,  200, 0, 0,   0,  5,  1, 0, 5, 1);
    vecs[13] = mk(0,  0,   1, 20,  0,  20, 1, 0, 6, 2);
    vecs[14] = mk(0,  0,   1, 40,  1,  20, 0, 1, 7, 2);
    vecs[15] = mk(1,  1022,0, 0,   0,  1022,1, 0, 0, 0);
    vecs[16] = mk(0,  0,   0, 0,   0,  1023,1, 0, 1, 0);
    vecs[17] = mk(0,  0,   0, 0,   0,  1023,0, 1, 2, 0);
    vecs[18] = mk(1,  1022,0, 0,   0,  1022,1, 0, 0, 0);
    vecs[19] = mk(0,  0,   0, 0,   0,  1023,1, 0, 1, 0);
    vecs[20] = mk(0,  0,   1, 0,   0,  0,  1, 0, 2, 1);
    vecs[21] = mk(0,  0,   0, 0,   0,  1,  1, 0, 3, 1);
    vecs[22] = mk(0,  0,   0, 0,   1,  1,  0, 1, 4, 1);
    vecs[23] = mk(1,  100, 0, 0,   0,  100,1, 0, 0, 0);
    vecs[24] = mk(0,  0,   0, 0,   0,  101,1, 0, 1, 0);

    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    check_all(100, 0, 0, 0, 0, 0);

    // Start while in reset has no effect
    drive(1, 10'd77, 0, 0, 0);
    @(posedge Clk); #1;
    check_all(101, 0, 0, 0, 0, 0);

    drive(0, 0, 1, 10'd9, 1);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_all(102, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].addr, vecs[i].br, vecs[i].tgt, vecs[i].halt);
      @(posedge Clk); #1;
      check_all(i, vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].ic, vecs[i].bc);
    end

    // Branch to 30 mid-run, then asynchronous reset between edges
    drive(0, 0, 1, 10'd30, 0);
    @(posedge Clk); #1;
    check_all(200, 30, 1, 0, 2, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    check_all(201, 0, 0, 0, 0, 0);
    drive(1, 10'd55, 0, 0, 0);
    @(posedge Clk); #1;
    check_all(202, 0, 0, 0, 0, 0);
    Reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    check_all(203, 0, 0, 0, 0, 0);
    drive(1, 10'd300, 0, 0, 0);
    @(posedge Clk); #1;
    check_all(204, 300, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    check_all(205, 301, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
